// File: rtl/blink_pkg.sv
// Shared types for the LED blinker bank: channel mode encoding and its width.
package blink_pkg;

  localparam int BL_MODE_W = 2;

  typedef enum logic [BL_MODE_W-1:0] {
    BL_OFF       = 2'd0,
    BL_ON        = 2'd1,
    BL_BLINK     = 2'd2,
    BL_PULSE_DIM = 2'd3
  } blink_mode_t;

endpackage

// File: rtl/blink_chan.sv
// One LED channel: registered mode, blink phase and LED output.
// With BLINK_DUTY_EN defined, mode 3 is DIM (compare cnt MSBs to duty) instead of PULSE.
module blink_chan
  import blink_pkg::*;
#(
  parameter int DBITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [BL_MODE_W-1:0] mode_i,
`ifdef BLINK_DUTY_EN
  input  logic [DBITS-1:0]     cnt_msb,
  input  logic [DBITS-1:0]     duty_i,
`endif
  output logic                 led
);

  blink_mode_t mode_in;
  blink_mode_t mode_q_reg;
  logic        phase_reg, phase_next;
  logic        led_reg, led_next;

  assign mode_in = blink_mode_t'(mode_i);

  // Any mode change restarts the blink dark; this takes priority over a tick.
  always_comb begin
    phase_next = phase_reg;
    if (mode_in != mode_q_reg)
      phase_next = 1'b0;
    else if (tick && mode_q_reg == BL_BLINK)
      phase_next = ~phase_reg;
  end

  always_comb begin
    led_next = 1'b0;
    case (mode_q_reg)
      BL_OFF:       led_next = 1'b0;
      BL_ON:        led_next = 1'b1;
      BL_BLINK:     led_next = phase_reg;
`ifdef BLINK_DUTY_EN
      BL_PULSE_DIM: led_next = (cnt_msb < duty_i);
`else
      BL_PULSE_DIM: led_next = tick;
`endif
      default:      led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q_reg <= BL_OFF;
      phase_reg  <= 1'b0;
      led_reg    <= 1'b0;
    end else begin
      mode_q_reg <= mode_in;
      phase_reg  <= phase_next;
      led_reg    <= led_next;
    end
  end

  assign led = led_reg;

endmodule

// File: rtl/blink_bank.sv
// Multi-channel LED blinker: shared prescaler, wrap strobe flg, NCH blink_chan instances.
// Optional macro BLINK_DUTY_EN adds the duty port and turns mode 3 into DIM.
module blink_bank
  import blink_pkg::*;
#(
  parameter int CBITS = 27,
  parameter int NCH   = 4,
  parameter int DBITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [BL_MODE_W*NCH-1:0] mode,
`ifdef BLINK_DUTY_EN
  input  logic [DBITS*NCH-1:0]     duty,
`endif
  output logic [NCH-1:0]           led,
  output logic                     flg
);

  logic [CBITS-1:0] cnt_reg, cnt_next;
  logic             flg_reg;
  logic             tick;

  if (NCH < 1 || NCH > 32 || DBITS < 1) begin : g_param_err
    $error("blink_bank: NCH must be 1..32 and DBITS >= 1");
  end

  assign tick     = en && (cnt_reg == {CBITS{1'b1}});
  assign cnt_next = en ? cnt_reg + 1'b1 : cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      flg_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      flg_reg <= tick;
    end
  end

  assign flg = flg_reg;

`ifdef BLINK_DUTY_EN
  if (CBITS < DBITS) begin : g_width_err
    $error("blink_bank: CBITS must be >= DBITS");
  end
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    blink_chan #(
      .DBITS(DBITS)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .mode_i (mode[gi*BL_MODE_W +: BL_MODE_W]),
`ifdef BLINK_DUTY_EN
      .cnt_msb(cnt_reg[CBITS-1 -: DBITS]),
      .duty_i (duty[gi*DBITS +: DBITS]),
`endif
      .led    (led[gi])
    );
  end

endmodule
